// File: rtl/rv32im_regfile_mp_pkg.sv
// Shared definitions for the multi-port register file and its scoreboard.
package rv32im_regfile_mp_pkg;

    // Default geometry of the integer register file.
    localparam int API_REGISTER_WIDTH      = 32;
    localparam int API_REGISTER_COUNT      = 32;
    localparam int API_REGISTER_ADDR_WIDTH = $clog2(API_REGISTER_COUNT);

    // x0 is hardwired to zero and can never be marked busy.
    localparam int ZERO_REG_ADDR = 0;

endpackage

// File: rtl/rv32im_regfile_scoreboard.sv
// Write-back scoreboard: one busy bit per architectural register.
// An issue sets the bit, a clearing write-back resets it; set wins so a
// newer issue is not lost behind an older write-back to the same register.
module rv32im_regfile_scoreboard
    import rv32im_regfile_mp_pkg::*;
#(
    parameter int NREGS = API_REGISTER_COUNT
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [NREGS-1:0] set_vec_i,
    input  logic [NREGS-1:0] clr_vec_i,
    output logic [NREGS-1:0] busy_vec_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Next busy state: set beats clear, register 0 pinned idle.
    always_comb begin
        busy_d                = (busy_q & ~clr_vec_i) | set_vec_i;
        busy_d[ZERO_REG_ADDR] = 1'b0;
    end

    // Busy bit storage, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec_o = busy_q;

endmodule

// File: rtl/rv32im_regfile_mp.sv
// Parametrised multi-port integer register file with optional write-to-read
// bypass, hardwired-zero x0 and an integrated write-back scoreboard.
module rv32im_regfile_mp
    import rv32im_regfile_mp_pkg::*;
#(
    parameter int  XLEN   = API_REGISTER_WIDTH,
    parameter int  NREGS  = API_REGISTER_COUNT,
    parameter int  NRD    = 2,
    parameter int  NWR    = 1,
    parameter int  BYPASS = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [NWR-1:0]      we_i,
    input  logic [NWR*AW-1:0]   rd_addr_i,
    input  logic [NWR*XLEN-1:0] val_rd_i,
    input  logic [NWR-1:0]      wb_clr_i,
    input  logic [NRD*AW-1:0]   rs_addr_i,
    output logic [NRD*XLEN-1:0] val_rs_o,
    output logic [NRD-1:0]      rs_busy_o,
    input  logic                issue_valid_i,
    input  logic [AW-1:0]       issue_rd_i,
    output logic [NREGS-1:0]    busy_vec_o
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;

    // Write arbitration: ports scanned in ascending order so the highest
    // index wins on a collision; x0 never changes.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            for (int k = 0; k < NWR; k++) begin
                if (we_i[k] && (rd_addr_i[k*AW +: AW] == AW'(i))) begin
                    regs_d[i] = val_rd_i[k*XLEN +: XLEN];
                end
            end
        end
        regs_d[ZERO_REG_ADDR] = '0;
    end

    // Register storage, cleared asynchronously (in-flight writes are lost).
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        for (int i = 0; i < NREGS; i++) begin
            if (!rst_n_i) begin
                regs_q[i] <= '0;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Decode issue and clearing write-backs into per-register vectors.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int i = 0; i < NREGS; i++) begin
            set_vec[i] = issue_valid_i && (issue_rd_i == AW'(i));
            for (int k = 0; k < NWR; k++) begin
                if (we_i[k] && wb_clr_i[k] && (rd_addr_i[k*AW +: AW] == AW'(i))) begin
                    clr_vec[i] = 1'b1;
                end
            end
        end
    end

    rv32im_regfile_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .set_vec_i  (set_vec),
        .clr_vec_i  (clr_vec),
        .busy_vec_o (busy_vec_o)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]   addr;
            logic [XLEN-1:0] data;
            logic            busy;
            logic            clr_hit;

            assign addr = rs_addr_i[gi*AW +: AW];

            // Read mux with optional bypass; a bypassed clearing write also
            // hides the busy bit because the consumer gets the data now.
            always_comb begin
                data    = regs_q[addr];
                clr_hit = 1'b0;
                for (int k = 0; k < NWR; k++) begin
                    if ((BYPASS != 0) && we_i[k] && (rd_addr_i[k*AW +: AW] == addr)) begin
                        data = val_rd_i[k*XLEN +: XLEN];
                        if (wb_clr_i[k]) begin
                            clr_hit = 1'b1;
                        end
                    end
                end
                busy = busy_vec_o[addr] & ~clr_hit;
                if (addr == AW'(ZERO_REG_ADDR)) begin
                    data = '0;
                    busy = 1'b0;
                end
            end

            assign val_rs_o[gi*XLEN +: XLEN] = data;
            assign rs_busy_o[gi]             = busy;
        end
    endgenerate

endmodule

// File: tb/tb_rv32im_regfile_mp.sv
// Bench for rv32im_regfile_mp (NRD=2, NWR=2, BYPASS=1): directed steps then a
// random issue/write-back stream, checked through an expected-value queue.
module tb_rv32im_regfile_mp;

    logic        clk_i;
    logic        rst_n_i;
    logic [1:0]  we_i;
    logic [9:0]  rd_addr_i;
    logic [63:0] val_rd_i;
    logic [1:0]  wb_clr_i;
    logic [9:0]  rs_addr_i;
    logic [63:0] val_rs_o;
    logic [1:0]  rs_busy_o;
    logic        issue_valid_i;
    logic [4:0]  issue_rd_i;
    logic [31:0] busy_vec_o;

    rv32im_regfile_mp #(
        .XLEN   (32),
        .NREGS  (32),
        .NRD    (2),
        .NWR    (2),
        .BYPASS (1)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .we_i          (we_i),
        .rd_addr_i     (rd_addr_i),
        .val_rd_i      (val_rd_i),
        .wb_clr_i      (wb_clr_i),
        .rs_addr_i     (rs_addr_i),
        .val_rs_o      (val_rs_o),
        .rs_busy_o     (rs_busy_o),
        .issue_valid_i (issue_valid_i),
        .issue_rd_i    (issue_rd_i),
        .busy_vec_o    (busy_vec_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } exp_t;

    exp_t        expq[$];
    int          n_vec;
    int          n_err;
    logic [31:0] mregs [32];
    logic [31:0] mbusy;

    task automatic push(input string tag, input logic [63:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        expq.push_back(e);
    endtask

    task automatic pop_check(input logic [63:0] obs);
        exp_t e;
        if (expq.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL queue_empty: observed %h expected an entry", obs);
        end else begin
            e = expq.pop_front();
            n_vec++;
            assert (obs === e.exp) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        mbusy = '0;
    endtask

    // One clock of stimulus: drive, check combinational reads, then check
    // the registered busy vector after the edge. Entered with clock low.
    task automatic cycle(input string tag, input logic [1:0] we,
                         input logic [4:0] wa0, input logic [4:0] wa1,
                         input logic [31:0] wd0, input logic [31:0] wd1,
                         input logic [1:0] clr,
                         input logic [4:0] ra0, input logic [4:0] ra1,
                         input logic iv, input logic [4:0] ird);
        logic [4:0]  wa [2];
        logic [31:0] wd [2];
        logic [4:0]  ra [2];
        logic [63:0] ev;
        logic [1:0]  eb;
        logic [31:0] nb;
        logic [31:0] v;
        logic        b;
        wa[0] = wa0; wa[1] = wa1;
        wd[0] = wd0; wd[1] = wd1;
        ra[0] = ra0; ra[1] = ra1;
        we_i          = we;
        rd_addr_i     = {wa1, wa0};
        val_rd_i      = {wd1, wd0};
        wb_clr_i      = clr;
        rs_addr_i     = {ra1, ra0};
        issue_valid_i = iv;
        issue_rd_i    = ird;
        for (int j = 0; j < 2; j++) begin
            v = mregs[ra[j]];
            b = mbusy[ra[j]];
            for (int k = 0; k < 2; k++) begin
                if (we[k] && wa[k] == ra[j]) begin
                    v = wd[k];
                    if (clr[k]) b = 1'b0;
                end
            end
            if (ra[j] == 5'd0) begin
                v = '0;
                b = 1'b0;
            end
            ev[j*32 +: 32] = v;
            eb[j]          = b;
        end
        push({tag, "_val_rs"}, ev);
        push({tag, "_rs_busy"}, {62'd0, eb});
        #1;
        pop_check(val_rs_o);
        pop_check({62'd0, rs_busy_o});
        @(posedge clk_i);
        nb = mbusy;
        for (int k = 0; k < 2; k++) begin
            if (we[k] && wa[k] != 5'd0) begin
                mregs[wa[k]] = wd[k];
                if (clr[k]) nb[wa[k]] = 1'b0;
            end
        end
        if (iv && ird != 5'd0) nb[ird] = 1'b1;
        mbusy = nb;
        push({tag, "_busy_vec"}, {32'd0, mbusy});
        #1;
        pop_check({32'd0, busy_vec_o});
        @(negedge clk_i);
    endtask

    task automatic check_all_zero(input string tag);
        push({tag, "_val_rs"}, 64'd0);
        push({tag, "_rs_busy"}, 64'd0);
        push({tag, "_busy_vec"}, 64'd0);
        pop_check(val_rs_o);
        pop_check({62'd0, rs_busy_o});
        pop_check({32'd0, busy_vec_o});
    endtask

    initial begin
        logic [1:0]  r_we;
        logic [1:0]  r_clr;
        logic [4:0]  r_wa0, r_wa1, r_ra0, r_ra1, r_ird;
        logic        r_iv;
        n_vec = 0;
        n_err = 0;
        model_reset();
        rst_n_i       = 1'b0;
        we_i          = '0;
        rd_addr_i     = '0;
        val_rd_i      = '0;
        wb_clr_i      = '0;
        rs_addr_i     = {5'd5, 5'd5};
        issue_valid_i = 1'b0;
        issue_rd_i    = '0;
        #2;
        check_all_zero("por");
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Pre-write x5 and make some registers busy, then reset mid-cycle.
        cycle("prewr",  2'b01, 5'd5, 5'd0, 32'h12345678, 32'h0, 2'b00, 5'd5, 5'd0, 1'b1, 5'd5);
        cycle("preiss", 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 5'd5, 5'd5, 1'b1, 5'd9);
        we_i          = '0;
        issue_valid_i = 1'b0;
        rs_addr_i     = {5'd9, 5'd5};
        #2;
        rst_n_i = 1'b0;
        #1;
        check_all_zero("midrst");
        model_reset();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        cycle("postrst", 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 5'd5, 5'd9, 1'b0, 5'd0);

        // Write x5 with a same-cycle bypassed read, then a plain read.
        cycle("wr_x5",  2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 2'b00, 5'd5, 5'd0, 1'b0, 5'd0);
        cycle("rd_x5",  2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 5'd0, 5'd5, 1'b0, 5'd0);

        // x0 stays zero and never busy.
        cycle("wr_x0",  2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 2'b01, 5'd0, 5'd0, 1'b1, 5'd0);
        cycle("rd_x0",  2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 5'd0, 5'd5, 1'b0, 5'd0);

        // Both ports hit x7: port 1 wins, in the bypass and in storage.
        cycle("dual_x7", 2'b11, 5'd7, 5'd7, 32'h11111111, 32'h22222222, 2'b00, 5'd7, 5'd7, 1'b0, 5'd0);
        cycle("rd_x7",   2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 5'd7, 5'd5, 1'b0, 5'd0);

        // Scoreboard: issue, clear-plus-issue keeps busy, clear releases.
        cycle("iss_x3",   2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 5'd3, 5'd3, 1'b1, 5'd3);
        cycle("busy_x3",  2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 5'd3, 5'd0, 1'b0, 5'd0);
        cycle("clr_iss3", 2'b10, 5'd0, 5'd3, 32'h0, 32'hA5A5A5A5, 2'b10, 5'd0, 5'd3, 1'b1, 5'd3);
        cycle("nclr_x3",  2'b01, 5'd3, 5'd0, 32'h0BADF00D, 32'h0, 2'b00, 5'd3, 5'd0, 1'b0, 5'd0);
        cycle("clr_x3",   2'b01, 5'd3, 5'd0, 32'hCAFEF00D, 32'h0, 2'b01, 5'd0, 5'd3, 1'b0, 5'd0);
        cycle("idle_x3",  2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 5'd3, 5'd3, 1'b0, 5'd0);

        // Random issue/write-back stream on a narrow address range.
        for (int n = 0; n < 10000; n++) begin
            r_we  = 2'($urandom_range(0, 3));
            r_clr = 2'($urandom_range(0, 3));
            r_wa0 = 5'($urandom_range(0, 7));
            r_wa1 = 5'($urandom_range(0, 7));
            r_ra0 = 5'($urandom_range(0, 7));
            r_ra1 = 5'($urandom_range(0, 7));
            r_iv  = 1'($urandom_range(0, 1));
            r_ird = 5'($urandom_range(0, 7));
            cycle("rand", r_we, r_wa0, r_wa1, $urandom(), $urandom(), r_clr,
                  r_ra0, r_ra1, r_iv, r_ird);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rv32im_regfile_mp.md
Name: rv32im_regfile_mp

Overview:
Parametrised multi-port integer register file with an integrated write-back scoreboard.
- Configurable register count, width, read-port count and write-port count.
- Optional same-cycle write-to-read bypass; hardwired-zero register 0.
- Per-register busy bits set at issue and cleared at write-back, for hazard detection.
- Sits between decode/issue and the execute/write-back stages of the dual-issue core.

Parameters:
XLEN, 32, register width in bits
NREGS, 32, number of architectural registers (power of 2, >=2)
NRD, 2, number of read ports (1..4)
NWR, 1, number of write ports (1..2)
BYPASS, 1, 1 = a read returns data being written in the same cycle; 0 = a read returns the stored value
AW, $clog2(NREGS), address width (localparam, not overridable)

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
we_i  in  NWR  per-port write enable
rd_addr_i  in  NWR*AW  write addresses, port k at [k*AW +: AW]
val_rd_i  in  NWR*XLEN  write data, port k at [k*XLEN +: XLEN]
wb_clr_i  in  NWR  per-port: this write also clears the scoreboard busy bit of rd_addr
rs_addr_i  in  NRD*AW  read addresses
val_rs_o  out  NRD*XLEN  read data (combinational)
rs_busy_o  out  NRD  busy status of each read address (combinational)
issue_valid_i  in  1  instruction issued that will write issue_rd_i
issue_rd_i  in  AW  destination of the issued instruction
busy_vec_o  out  NREGS  registered busy bits, bit i = register i

Behaviour:
- Reset (rst_n_i low, asynchronous): all registers = 0, all busy bits = 0. Hence val_rs_o = 0, rs_busy_o = 0, busy_vec_o = 0 while in reset.
- Write: on a rising clk_i with we_i[k]=1 and rd_addr k != 0, the register takes val_rd k.
  - Writes to address 0 are discarded.
  - If two ports write the same address in one cycle, the highest-index port wins.
- Read: val_rs j = 0 if rs_addr j == 0.
  - BYPASS=1: if any enabled write port targets rs_addr j (non-zero) this cycle, output that port's data (highest-index port wins). Otherwise output the stored value.
  - BYPASS=0: always output the stored value. New data is visible the cycle after the write.
- Scoreboard (sequential, per register i != 0), evaluated each clock edge:
  - set = issue_valid_i and issue_rd_i == i
  - clr = any port k with we_i[k], wb_clr_i[k], rd_addr k == i
  - next busy = set ? 1 : (clr ? 0 : busy). Set beats clear: an older write-back and a newer issue to the same register leave it busy.
  - Register 0 is never busy; issue to 0 is ignored.
  - we_i=1 with wb_clr_i=0 writes data but leaves busy unchanged (used for non-scoreboarded writes).
- rs_busy j = busy[rs_addr j], with these overrides:
  - BYPASS=1 and a clearing write to rs_addr j is in flight this cycle: rs_busy j = 0, because the data is bypassed.
  - rs_addr j == 0: rs_busy j = 0.
  - An issue in the same cycle does not affect rs_busy j until the next cycle.
- Reset mid-operation: all state returns to zero immediately; in-flight writes are lost.
- Latency: read 0 cycles (combinational); write and busy updates 1 cycle.
- Out-of-range addresses cannot occur (NREGS is a power of 2).

Decomposition:
- Shared definitions header: API_REGISTER_WIDTH, API_REGISTER_COUNT, API_REGISTER_ADDR_WIDTH as defaults for XLEN/NREGS/AW, and a zero-register address constant.
- One sub-module, rv32im_regfile_scoreboard: busy-bit array plus set/clear priority logic. Ports: clk_i, rst_n_i, issue, clear vectors, busy_vec_o.
- Storage, write arbitration and read/bypass muxing stay in the top level.

Test Plan:
- Reset with registers pre-written: assert rst_n_i low mid-cycle -> val_rs_o and busy_vec_o = 0 before the next edge; reads of x5 after release return 0x00000000.
- Write x5 = 0xDEADBEEF; same-cycle read of x5 -> BYPASS=1: 0xDEADBEEF; BYPASS=0: old value, then 0xDEADBEEF the next cycle.
- Write x0 = 0xFFFFFFFF with wb_clr=1, issue to x0 -> x0 reads 0, busy_vec_o[0] stays 0.
- NWR=2, both ports write x7 (port0 0x11111111, port1 0x22222222) -> x7 = 0x22222222; the bypassed read also returns 0x22222222.
- Issue x3 -> busy_vec_o[3]=1 next cycle. Write-back x3 with wb_clr and a new issue to x3 in the same cycle -> busy stays 1. Clearing write with no issue -> busy 0 next cycle; rs_busy for x3 = 0 in the clearing cycle when BYPASS=1.
- Randomised issue/write-back stream checked against a reference model for 10k cycles -> no mismatch in val_rs_o, rs_busy_o or busy_vec_o.
